// File: rtl/asteroid_renderer.sv
// Asteroid renderer: snapshots the 8 asteroid slots on frame_tick, then erases and redraws each square.
// Latency: a pass ends with done 10 + k*SIZE*SIZE cycles after the sampling edge (k = erase + draw phases).
// Backpressure: none; one pixel write per cycle, and frame_tick while busy is dropped and flagged on overrun.
module asteroid_renderer #(
  parameter int         SIZE      = 4,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120
) (
  input  logic        game_clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [7:0]  moving_block,
  input  logic [63:0] x_coords,
  input  logic [55:0] y_coords,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, LATCH, SCAN, ERASE, DRAW, FIN} state_t;

  localparam logic [3:0] LAST  = 4'(SIZE - 1);
  localparam logic [8:0] SCR_W = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H = 8'(SCREEN_H);

  state_t          state, next_state;
  logic [2:0]      slot;
  logic [3:0]      dx, dy;
  logic [7:0]      cur_moving;
  logic [7:0][7:0] cur_x;
  logic [7:0][6:0] cur_y;
  logic [7:0][7:0] prev_x;
  logic [7:0][6:0] prev_y;
  logic [7:0]      prev_drawn;

  logic       advance, pix_on, last_pix, on_screen;
  logic [2:0] pix_colour;
  logic [7:0] ox;
  logic [6:0] oy;
  logic [8:0] px;
  logic [7:0] py;

  assign busy     = (state != IDLE);
  assign last_pix = (dx == LAST) && (dy == LAST);

  // Next-state logic and the pixel being addressed this cycle.
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    pix_on     = 1'b0;
    pix_colour = FG_COLOUR;
    ox         = cur_x[slot];
    oy         = cur_y[slot];
    case (state)
      IDLE:  if (frame_tick) next_state = LATCH;
      LATCH: next_state = SCAN;
      SCAN: begin
        if (prev_drawn[slot])      next_state = ERASE;
        else if (cur_moving[slot]) next_state = DRAW;
        else                       advance    = 1'b1;
      end
      ERASE: begin
        pix_on     = 1'b1;
        pix_colour = BG_COLOUR;
        ox         = prev_x[slot];
        oy         = prev_y[slot];
        if (last_pix) begin
          if (cur_moving[slot]) next_state = DRAW;
          else                  advance    = 1'b1;
        end
      end
      DRAW: begin
        pix_on = 1'b1;
        if (last_pix) advance = 1'b1;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (advance) next_state = (slot == 3'd7) ? FIN : SCAN;
    px        = {1'b0, ox} + {5'b0, dx};
    py        = {1'b0, oy} + {4'b0, dy};
    on_screen = (px < SCR_W) && (py < SCR_H);
  end

  // State, shadow/previous-pass registers, pixel counters and registered outputs.
  always_ff @(posedge game_clk) begin
    if (reset) begin
      state      <= IDLE;
      slot       <= 3'd0;
      dx         <= 4'd0;
      dy         <= 4'd0;
      cur_moving <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_drawn <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state   <= next_state;
      done    <= (state == FIN);
      overrun <= frame_tick && (state != IDLE);
      plot    <= pix_on && on_screen;
      if (pix_on && on_screen) begin
        vga_x      <= px[7:0];
        vga_y      <= py[6:0];
        vga_colour <= pix_colour;
      end
      if (state == LATCH) begin
        cur_moving <= moving_block;
        cur_x      <= x_coords;
        cur_y      <= y_coords;
        slot       <= 3'd0;
      end
      // Square pixels walk row-major; counters return to 0 after each square.
      if (pix_on) begin
        if (last_pix) begin
          dx <= 4'd0;
          dy <= 4'd0;
        end else if (dx == LAST) begin
          dx <= 4'd0;
          dy <= dy + 4'd1;
        end else begin
          dx <= dx + 4'd1;
        end
      end
      if (advance) begin
        prev_x[slot]     <= cur_x[slot];
        prev_y[slot]     <= cur_y[slot];
        prev_drawn[slot] <= cur_moving[slot];
        if (slot != 3'd7) slot <= slot + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_asteroid_renderer.sv
module tb_asteroid_renderer;

  localparam int SQ = 16;

  logic        game_clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [7:0]  moving_block = '0;
  logic [63:0] x_coords = '0;
  logic [55:0] y_coords = '0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot, busy, done, overrun;

  always #5 game_clk = ~game_clk;

  asteroid_renderer dut (
    .game_clk(game_clk), .reset(reset), .frame_tick(frame_tick),
    .moving_block(moving_block), .x_coords(x_coords), .y_coords(y_coords),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done), .overrun(overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what each slot looked like on screen after the last pass.
  int  m_px[8];
  int  m_py[8];
  bit  m_pd[8];
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic add_square(input int ox, input int oy, input logic [2:0] col);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        if (ox + x < 160 && oy + y < 120)
          exp_q.push_back({8'(ox + x), 7'(oy + y), col});
  endtask

  task automatic model_pass(input logic [7:0] mb, input logic [63:0] xc, input logic [55:0] yc,
                            output int k);
    exp_q.delete();
    k = 0;
    for (int s = 0; s < 8; s++) begin
      if (m_pd[s]) begin
        add_square(m_px[s], m_py[s], 3'b000);
        k++;
      end
      if (mb[s]) begin
        add_square(int'(xc[8*s +: 8]), int'(yc[7*s +: 7]), 3'b111);
        k++;
      end
      m_pd[s] = mb[s];
      m_px[s] = int'(xc[8*s +: 8]);
      m_py[s] = int'(yc[7*s +: 7]);
    end
  endtask

  // inj: -1 no extra tick, -2 tick during FIN, else edge index at which a tick is sampled.
  task automatic run_pass(input string tag, input logic [7:0] mb, input logic [63:0] xc,
                          input logic [55:0] yc, input int inj_in, output int nplot);
    int k, n, busy_cnt, done_at, inj, ne;
    model_pass(mb, xc, yc, k);
    inj = (inj_in == -2) ? 10 + k * SQ : inj_in;
    @(negedge game_clk);
    moving_block = mb;
    x_coords     = xc;
    y_coords     = yc;
    frame_tick   = 1'b1;
    @(posedge game_clk);
    #1;
    frame_tick = 1'b0;
    obs_q.delete();
    n = 0;
    busy_cnt = 0;
    done_at = -1;
    while (n < 400) begin
      if (busy) busy_cnt++;
      if (plot) obs_q.push_back({vga_x, vga_y, vga_colour});
      check({tag, "_overrun"}, 32'(overrun), 32'(n == inj));
      if (done) begin
        done_at = n;
        break;
      end
      if (n == 1) begin
        moving_block = 8'($urandom);
        x_coords     = {$urandom, $urandom};
        y_coords     = 56'({$urandom, $urandom});
      end
      frame_tick = (n + 1 == inj);
      @(posedge game_clk);
      #1;
      n++;
    end
    frame_tick = 1'b0;
    check({tag, "_done_edge"}, 32'(done_at), 32'(10 + k * SQ));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(10 + k * SQ));
    check({tag, "_plot_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    ne = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int j = 0; j < ne; j++)
      check({tag, "_pixel"}, 32'(obs_q[j]), 32'(exp_q[j]));
    @(posedge game_clk);
    #1;
    check({tag, "_idle_after"}, 32'({busy, done}), 32'(0));
    nplot = obs_q.size();
  endtask

  initial begin
    int np, cnt;
    for (int s = 0; s < 8; s++) begin
      m_pd[s] = 1'b0;
      m_px[s] = 0;
      m_py[s] = 0;
    end

    // Reset held with random inputs: every output quiet.
    reset = 1'b1;
    repeat (3) begin
      @(negedge game_clk);
      frame_tick   = 1'($urandom);
      moving_block = 8'($urandom);
      x_coords     = {$urandom, $urandom};
      y_coords     = 56'({$urandom, $urandom});
    end
    @(posedge game_clk);
    #1;
    check("reset_outputs", 32'({vga_x, vga_y, vga_colour, plot, busy, done, overrun}), 32'(0));
    @(negedge game_clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(posedge game_clk);
      #1;
      if (plot || busy) cnt++;
    end
    check("idle_no_plot", 32'(cnt), 32'(0));

    // Single draw, then move right by one, then clear.
    run_pass("draw_s0", 8'h01, 64'd10, 56'd20, -1, np);
    check("draw_s0_n", 32'(np), 32'(16));
    run_pass("move_s0", 8'h01, 64'd11, 56'd20, -1, np);
    check("move_s0_n", 32'(np), 32'(32));
    run_pass("clear_s0", 8'h00, 64'd0, 56'd0, -1, np);
    check("clear_s0_n", 32'(np), 32'(16));

    // Screen-corner clipping on slot 3.
    run_pass("corner_s3", 8'h08, 64'd158 << 24, 56'd118 << 21, -1, np);
    check("corner_s3_n", 32'(np), 32'(4));
    run_pass("corner_erase", 8'h00, 64'd0, 56'd0, -1, np);
    check("corner_erase_n", 32'(np), 32'(4));

    // Extra frame_tick mid-pass and in FIN.
    run_pass("ovr_mid", 8'h01, 64'd10, 56'd20, 5, np);
    run_pass("ovr_fin", 8'h01, 64'd10, 56'd20, -2, np);

    // Reset mid-DRAW of slot 0 (erase occupies plots at edges 3..18, draw 19..34).
    @(negedge game_clk);
    moving_block = 8'h01;
    x_coords     = 64'd10;
    y_coords     = 56'd20;
    frame_tick   = 1'b1;
    @(posedge game_clk);
    #1;
    frame_tick = 1'b0;
    repeat (24) @(posedge game_clk);
    #1;
    check("mid_draw_colour", 32'({plot, vga_colour}), 32'({1'b1, 3'b111}));
    reset = 1'b1;
    @(posedge game_clk);
    #1;
    check("rst_mid_plot", 32'({plot, busy}), 32'(0));
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge game_clk);
      #1;
      if (done || plot) cnt++;
    end
    check("rst_no_done", 32'(cnt), 32'(0));
    for (int s = 0; s < 8; s++) m_pd[s] = 1'b0;
    run_pass("after_rst", 8'h01, 64'd10, 56'd20, -1, np);
    check("after_rst_n", 32'(np), 32'(16));

    // Randomised passes, some with a stray frame_tick.
    for (int t = 0; t < 10; t++) begin
      int inj;
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 9)) : -1;
      run_pass("rand", 8'($urandom), {$urandom, $urandom}, 56'({$urandom, $urandom}), inj, np);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/asteroid_renderer.md
Name: asteroid_renderer

Overview:
- Reader side of the asteroid generator's packed coordinate bus (moving_block / x_coords / y_coords).
- Once per frame it snapshots all 8 asteroid slots and emits one VGA-adapter pixel write per cycle.
- For each slot it erases the square drawn on the previous pass, then draws the square at the new position.
- Sits between the asteroid generator and the VGA adapter's x/y/colour/plot inputs.

Parameters:
SIZE, 4, edge length in pixels of each asteroid square; power of two, 1..8
FG_COLOUR, 3'b111, colour used to draw asteroids
BG_COLOUR, 3'b000, colour used to erase
SCREEN_W, 160, pixels with x >= SCREEN_W are not plotted
SCREEN_H, 120, pixels with y >= SCREEN_H are not plotted

Ports:
game_clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
frame_tick  input  1  single-cycle pulse that requests a redraw pass
moving_block  input  8  bit i = slot i active
x_coords  input  64  slot i x = x_coords[8i+7:8i]
y_coords  input  56  slot i y = y_coords[7i+6:7i]
vga_x  output  8  pixel x, registered
vga_y  output  7  pixel y, registered
vga_colour  output  3  pixel colour, registered
plot  output  1  pixel write strobe, registered
busy  output  1  high while a pass is in progress
done  output  1  one-cycle pulse at the end of a pass
overrun  output  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Shadow and previous-pass registers cleared; all prev_drawn bits 0.
- Reset asserted mid-pass:
  - plot is 0 from the next cycle onward.
  - The pass is abandoned and no done pulse is issued.
  - prev_drawn is cleared, so the next pass performs no erases. The top level clears the screen on reset.
- FSM states: IDLE, LATCH, SCAN, ERASE, DRAW, FIN.
- IDLE:
  - busy = 0.
  - When frame_tick = 1, go to LATCH.
- LATCH (1 cycle):
  - Copy moving_block, x_coords and y_coords into cur_* shadow registers. Inputs are not sampled again during the pass.
  - Set slot index i = 0.
  - Go to SCAN.
- SCAN (1 cycle per slot), in priority order:
  - If prev_drawn[i] = 1, go to ERASE at prev_x[i], prev_y[i].
  - Else if cur_moving[i] = 1, go to DRAW at cur_x[i], cur_y[i].
  - Else advance to the next slot.
- ERASE (SIZE² cycles):
  - One pixel per cycle, colour BG_COLOUR.
  - On the last pixel: go to DRAW if cur_moving[i] = 1, else advance to the next slot.
- DRAW (SIZE² cycles):
  - One pixel per cycle, colour FG_COLOUR.
  - On the last pixel, advance to the next slot.
- Advance to the next slot:
  - Update prev_x[i] = cur_x[i], prev_y[i] = cur_y[i], prev_drawn[i] = cur_moving[i].
  - If i = 7, go to FIN; else increment i and go to SCAN.
- FIN (1 cycle): done = 1, then go to IDLE.
- Pixel order: row-major, dx fastest, dx and dy each running 0..SIZE-1.
- Pixel address arithmetic:
  - px = {1'b0, ox} + dx (9-bit); py = {1'b0, oy} + dy (8-bit). No wrap-around.
  - If px >= SCREEN_W or py >= SCREEN_H: plot = 0 for that cycle, but the cycle is still consumed.
  - Otherwise vga_x = px[7:0], vga_y = py[6:0], plot = 1.
- Outputs:
  - plot, vga_x, vga_y and vga_colour are registered and valid in the same cycle.
  - plot = 0 in IDLE, LATCH, SCAN and FIN.
  - busy = 1 in LATCH through FIN inclusive.
- Timing:
  - Let k = number of erase phases + number of draw phases in a pass.
  - done is high exactly 10 + k·SIZE² cycles after the edge that sampled frame_tick.
  - Minimum pass (k = 0) = 10 cycles.
- frame_tick while busy:
  - Ignored, not queued.
  - overrun pulses for 1 cycle.
  - frame_tick in the FIN cycle is also ignored and raises overrun.
- Changes on the coordinate inputs during a pass have no effect until the next LATCH.

Test Plan:
1. Reset held for 3 cycles with random inputs → plot, busy, done, overrun, vga_x, vga_y and vga_colour all 0; no plot when frame_tick is held low.
2. moving_block = 8'h01, slot 0 at (10,20), frame_tick → 16 plots with colour 111: x 10..13 fastest, y 20..23; done at edge 26; busy is high for 26 cycles.
3. Follow-up pass with slot 0 at (11,20) → 16 plots colour 000 at (10..13, 20..23), then 16 plots colour 111 at (11..14, 20..23); done at edge 42.
4. Slot 3 at (158,118), only that slot active → exactly 4 plots, at (158,118), (159,118), (158,119), (159,119); done still at edge 26. A third pass with moving_block = 0 → 4 erase plots only, done at edge 26.
5. frame_tick pulsed 5 cycles into a pass → overrun = 1 for one cycle, the pass is unaffected, and exactly one done is produced; a frame_tick in the FIN cycle also gives overrun.
6. Reset asserted mid-DRAW of slot 0 (drawn at (10,20) on the previous pass) → plot = 0 next cycle and no done; the next pass with the same inputs gives 16 draw plots and no erase.
